// File: rtl/multicycle_control.sv
// Multicycle ARM-subset controller: instruction-step FSM, NZCV flags, condition-gated writes.
// Latency 2 to 5 cycles per instruction; no backpressure, the FSM advances every cycle.
module multicycle_control #(
   parameter int ALUCTRL_W = 2,
   parameter int COND_EN   = 1,
   parameter int STATE_W   = 4
) (
   input  logic                 iClk,
   input  logic                 iRst_n,
   input  logic [3:0]           iCond,
   input  logic [1:0]           iOp,
   input  logic [5:0]           iFunct,
   input  logic [3:0]           iRd,
   input  logic [3:0]           iALUFlags,
   output logic                 oPCWrite,
   output logic                 oRegWrite,
   output logic                 oMemWrite,
   output logic                 oIRWrite,
   output logic                 oAdrSrc,
   output logic [1:0]           oResultSrc,
   output logic                 oALUSrcA,
   output logic [1:0]           oALUSrcB,
   output logic [1:0]           oImmSrc,
   output logic [1:0]           oRegSrc,
   output logic [ALUCTRL_W-1:0] oALUControl,
   output logic [3:0]           oFlags,
   output logic [STATE_W-1:0]   oState
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   typedef struct packed {
      logic       ir_write;
      logic       next_pc;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
      logic       alu_op;
      logic       adr_src;
      logic [1:0] result_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
   } ctl_t;

   localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
   localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
   localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
   localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);
   localparam logic [ALUCTRL_W-1:0] ALU_EOR = ALUCTRL_W'(4);

   state_t               state;
   ctl_t                 ctl;
   logic [ALUCTRL_W-1:0] alu_sel;
   logic                 alu_bad;
   logic                 is_cmp;
   logic                 no_write;
   logic [1:0]           flag_w;
   logic                 fn, fz, fc, fv;
   logic                 cond_hit;
   logic                 cond_ex;
   logic                 reg_w_eff;
   logic                 pcs;

   function automatic state_t next_of(input state_t s, input logic [1:0] op, input logic [5:0] funct);
      state_t n;
      n = FETCH;
      case (s)
         FETCH:  n = DECODE;
         DECODE: begin
            case (op)
               2'b00:   n = funct[5] ? EXECI : EXECR;
               2'b01:   n = MEMADR;
               2'b10:   n = BRANCH;
               default: n = FETCH;
            endcase
         end
         MEMADR:       n = funct[0] ? MEMRD : MEMWR;
         MEMRD:        n = MEMWB;
         EXECR, EXECI: n = ALUWB;
         default:      n = FETCH;
      endcase
      return n;
   endfunction

   function automatic ctl_t ctl_of(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.ir_write   = 1'b1;
            c.next_pc    = 1'b1;
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         DECODE: begin
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         MEMADR: c.alu_src_b = 2'b01;
         MEMRD:  c.adr_src = 1'b1;
         MEMWB: begin
            c.result_src = 2'b01;
            c.reg_w      = 1'b1;
         end
         MEMWR: begin
            c.adr_src = 1'b1;
            c.mem_w   = 1'b1;
         end
         EXECR:  c.alu_op = 1'b1;
         EXECI: begin
            c.alu_src_b = 2'b01;
            c.alu_op    = 1'b1;
         end
         ALUWB:  c.reg_w = 1'b1;
         BRANCH: begin
            c.alu_src_b  = 2'b01;
            c.result_src = 2'b10;
            c.branch     = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Controls are registered alongside the state, decoded from the state being entered.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state  <= FETCH;
         ctl    <= ctl_of(FETCH);
         oFlags <= 4'b0000;
      end else begin
         state <= next_of(state, iOp, iFunct);
         ctl   <= ctl_of(next_of(state, iOp, iFunct));
         if (ctl.alu_op && cond_ex) begin
            if (flag_w[1]) oFlags[3:2] <= iALUFlags[3:2];
            if (flag_w[0]) oFlags[1:0] <= iALUFlags[1:0];
         end
      end
   end

   always_comb begin
      alu_sel = ALU_ADD;
      alu_bad = 1'b0;
      is_cmp  = 1'b0;
      case (iFunct[4:1])
         4'b0100: alu_sel = ALU_ADD;
         4'b0010: alu_sel = ALU_SUB;
         4'b0000: alu_sel = ALU_AND;
         4'b1100: alu_sel = ALU_ORR;
         4'b0001: begin
            if (ALUCTRL_W >= 3) alu_sel = ALU_EOR;
            else                alu_bad = 1'b1;
         end
         4'b1010: begin
            if (ALUCTRL_W >= 3) begin
               alu_sel = ALU_SUB;
               is_cmp  = 1'b1;
            end else begin
               alu_bad = 1'b1;
            end
         end
         default: alu_bad = 1'b1;
      endcase
   end

   assign no_write = alu_bad | is_cmp;
   assign flag_w   = alu_bad ? 2'b00 :
                     is_cmp  ? 2'b11 :
                     {iFunct[0], iFunct[0] & ((alu_sel == ALU_ADD) | (alu_sel == ALU_SUB))};

   assign {fn, fz, fc, fv} = oFlags;

   always_comb begin
      cond_hit = 1'b0;
      case (iCond)
         4'h0: cond_hit = fz;
         4'h1: cond_hit = ~fz;
         4'h2: cond_hit = fc;
         4'h3: cond_hit = ~fc;
         4'h4: cond_hit = fn;
         4'h5: cond_hit = ~fn;
         4'h6: cond_hit = fv;
         4'h7: cond_hit = ~fv;
         4'h8: cond_hit = fc & ~fz;
         4'h9: cond_hit = ~fc | fz;
         4'hA: cond_hit = (fn == fv);
         4'hB: cond_hit = (fn != fv);
         4'hC: cond_hit = ~fz & (fn == fv);
         4'hD: cond_hit = fz | (fn != fv);
         4'hE: cond_hit = 1'b1;
         default: cond_hit = 1'b0;
      endcase
   end

   assign cond_ex = (COND_EN == 0) ? 1'b1 : cond_hit;

   // Unsupported ALU codes and CMP drop the register write-back but still walk ALUWB.
   assign reg_w_eff = ctl.reg_w & ~(no_write & (state == ALUWB));
   assign pcs       = ((iRd == 4'hF) & reg_w_eff) | ctl.branch;

   assign oPCWrite    = ctl.next_pc | (pcs & cond_ex);
   assign oRegWrite   = reg_w_eff & cond_ex;
   assign oMemWrite   = ctl.mem_w & cond_ex;
   assign oIRWrite    = ctl.ir_write;
   assign oAdrSrc     = ctl.adr_src;
   assign oResultSrc  = ctl.result_src;
   assign oALUSrcA    = ctl.alu_src_a;
   assign oALUSrcB    = ctl.alu_src_b;
   assign oImmSrc     = iOp;
   assign oRegSrc     = {iOp == 2'b01, iOp == 2'b10};
   assign oALUControl = ctl.alu_op ? alu_sel : ALU_ADD;
   assign oState      = STATE_W'(state);

endmodule
